// File: rtl/cochlea_chan_ctrl_if.sv
// Event stream between the cochlea controller and its consumer.
// The producer holds an entry on ev_data while ev_valid is high; the consumer
// pops the head by asserting ev_ready.
interface cochlea_chan_ctrl_if #(
    parameter int TS_W = 16
);
    logic                ev_valid;
    logic                ev_ready;
    logic [3+1+TS_W-1:0] ev_data;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/cochlea_chan_ctrl.sv
// cochlea_chan_ctrl: digital side of the 8-channel analog cochlea core.
// Generates the channel clocks (cclk, div2, lo), captures each channel's
// comparator decision on its event clock, and turns polarity changes into
// timestamped events queued in a small FIFO.
module cochlea_chan_ctrl #(
    parameter int N_CH       = 8,
    parameter int DIV_W      = 8,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int Q_PHASE    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [DIV_W-1:0]    div_val,
    input  logic [N_CH-1:0]     high_buf,
    input  logic [N_CH-1:0]     phi1b_dig,
    output logic [N_CH-1:0]     cclk,
    output logic [N_CH-1:0]     div2,
    output logic [N_CH-1:0]     lo,
    output logic [N_CH-1:0]     fb1,
    cochlea_chan_ctrl_if.master ev,
    output logic                ovf,
    input  logic                ovf_clr
);
    localparam int CH_W  = 3;
    localparam int EV_W  = CH_W + 1 + TS_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // ---------------- clock generation ----------------
    logic [DIV_W-1:0] presc_q, div_q;
    logic             cclk_q, div2_q, lo_q;
    logic [1:0]       phase_q, phase_nxt;
    logic             lo_nxt;

    assign phase_nxt = phase_q + 2'd1;
    assign lo_nxt    = (Q_PHASE != 0) ? (phase_nxt[1] ^ phase_nxt[0]) : phase_nxt[1];

    // Prescaler, cclk toggle, and phase/div2/lo advance on each cclk rising toggle.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            div_q   <= '0;
            cclk_q  <= 1'b0;
            div2_q  <= 1'b0;
            lo_q    <= 1'b0;
            phase_q <= '0;
        end else if (!en) begin
            presc_q <= '0;
            div_q   <= div_val;
            cclk_q  <= 1'b0;
            div2_q  <= 1'b0;
            lo_q    <= 1'b0;
            phase_q <= '0;
        end else if (presc_q == div_q) begin
            presc_q <= '0;
            div_q   <= div_val;
            cclk_q  <= ~cclk_q;
            if (!cclk_q) begin
                phase_q <= phase_nxt;
                div2_q  <= ~div2_q;
                lo_q    <= lo_nxt;
            end
        end else begin
            presc_q <= presc_q + DIV_W'(1);
        end
    end

    assign cclk = {N_CH{cclk_q}};
    assign div2 = {N_CH{div2_q}};
    assign lo   = {N_CH{lo_q}};

    // ---------------- timestamp ----------------
    logic [TS_W-1:0] ts_q;

    // Free-running timestamp, frozen while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  ts_q <= '0;
        else if (en) ts_q <= ts_q + TS_W'(1);
    end

    // ---------------- synchronizers and edge detect ----------------
    logic [N_CH-1:0] hb_s1_q, hb_s2_q, phi_s1_q, phi_s2_q, phi_s3_q;
    logic [N_CH-1:0] phi_rise, new_ev, fb1_q;

    // Two-flop synchronizers plus a delayed phi copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_s1_q  <= '0;
            hb_s2_q  <= '0;
            phi_s1_q <= '0;
            phi_s2_q <= '0;
            phi_s3_q <= '0;
        end else begin
            hb_s1_q  <= high_buf;
            hb_s2_q  <= hb_s1_q;
            phi_s1_q <= phi1b_dig;
            phi_s2_q <= phi_s1_q;
            phi_s3_q <= phi_s2_q;
        end
    end

    assign phi_rise = en ? (phi_s2_q & ~phi_s3_q) : '0;
    assign new_ev   = phi_rise & (hb_s2_q ^ fb1_q);

    // Feedback register: latest synced comparator decision per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fb1_q <= '0;
        else        fb1_q <= (fb1_q & ~phi_rise) | (hb_s2_q & phi_rise);
    end

    assign fb1 = fb1_q;

    // ---------------- arbiter ----------------
    logic [N_CH-1:0] pend_q, pend_pol_q, push_mask;
    logic [TS_W-1:0] pend_ts_q [N_CH];
    logic [CH_W-1:0] push_ch;
    logic            pend_any, push, pop, fifo_full;
    logic [PTR_W:0]  count_q;

    // Lowest-index pending channel wins the single push slot.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pend_any = 1'b0;
        push_ch  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pend_any = 1'b1;
                push_ch  = CH_W'(i);
            end
        end
    end

    assign fifo_full = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign push      = pend_any & ~fifo_full;
    assign push_mask = push ? (N_CH'(1) << push_ch) : '0;
    assign pop       = ev.ev_ready & (count_q != '0);

    // Pending slots: a new detection overrides a same-cycle push clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_pol_q <= '0;
            for (int i = 0; i < N_CH; i++) pend_ts_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (new_ev[i]) begin
                    pend_q[i]     <= 1'b1;
                    pend_pol_q[i] <= hb_s2_q[i];
                    pend_ts_q[i]  <= ts_q;
                end else if (push_mask[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky overflow: a detection on a still-pending, not-just-pushed slot loses an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else        ovf <= (|(new_ev & pend_q & ~push_mask)) | (ovf & ~ovf_clr);
    end

    // ---------------- event FIFO ----------------
    logic [EV_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage, written with the arbitrated channel's pending data.
    // NOTE: the storage array is not reset; ev_valid qualifies the head, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {push_ch, pend_pol_q[push_ch], pend_ts_q[push_ch]};
    end

    assign ev.ev_valid = (count_q != '0);
    assign ev.ev_data  = ev.ev_valid ? mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_cochlea_chan_ctrl.sv
// Self-checking bench for cochlea_chan_ctrl: a cycle-level behavioural model
// (plain integers and a queue) is compared against the DUT on every cycle,
// with directed scenarios pinning literal expectations.
module tb_cochlea_chan_ctrl;
    localparam int TS_W    = 16;
    localparam int Q_PHASE = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic [7:0] high_buf = 8'd0;
    logic [7:0] phi1b_dig = 8'd0;
    logic [7:0] cclk, div2, lo, fb1;
    logic       ovf;

    cochlea_chan_ctrl_if #(.TS_W(TS_W)) ev_if ();

    cochlea_chan_ctrl #(
        .N_CH(8), .DIV_W(8), .TS_W(TS_W), .FIFO_DEPTH(8), .Q_PHASE(Q_PHASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div_val(div_val),
        .high_buf(high_buf), .phi1b_dig(phi1b_dig),
        .cclk(cclk), .div2(div2), .lo(lo), .fb1(fb1),
        .ev(ev_if), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    int          m_cnt, m_div, m_phase;
    logic        m_cclk, m_div2, m_lo, m_ovf;
    logic [15:0] m_ts;
    logic [7:0]  m_fb1, m_pend, m_pol;
    logic [15:0] m_pts [8];
    logic [19:0] m_q [$];
    logic [7:0]  h_hb [3];   // input samples: [0] = previous edge, [2] = three edges back
    logic [7:0]  h_phi [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_div = 0; m_phase = 0;
            m_cclk = 0; m_div2 = 0; m_lo = 0; m_ovf = 0;
            m_ts = 0; m_fb1 = 0; m_pend = 0; m_pol = 0;
            for (int i = 0; i < 8; i++) m_pts[i] = 0;
            for (int i = 0; i < 3; i++) begin h_hb[i] = 0; h_phi[i] = 0; end
            m_q.delete();
        end else begin : step
            logic [7:0] rise, d;
            int         pch;
            logic       set_ovf, can_push;
            // An event-clock edge reaches the logic two edges after it is sampled.
            rise = en ? (h_phi[1] & ~h_phi[2]) : 8'd0;
            d    = h_hb[1];
            can_push = (m_q.size() < 8);
            if (ev_if.ev_ready && m_q.size() > 0) void'(m_q.pop_front());
            pch = -1;
            for (int i = 0; i < 8; i++) if (m_pend[i] && pch < 0) pch = i;
            if (pch >= 0 && can_push) begin
                m_q.push_back({3'(pch), m_pol[pch], m_pts[pch]});
                m_pend[pch] = 1'b0;
            end
            set_ovf = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (rise[i]) begin
                    if (d[i] != m_fb1[i]) begin
                        if (m_pend[i]) set_ovf = 1'b1;
                        m_pend[i] = 1'b1;
                        m_pol[i]  = d[i];
                        m_pts[i]  = m_ts;
                    end
                    m_fb1[i] = d[i];
                end
            end
            m_ovf = set_ovf | (m_ovf & ~ovf_clr);
            if (!en) begin
                m_cnt = 0; m_div = int'(div_val); m_cclk = 0; m_phase = 0; m_div2 = 0; m_lo = 0;
            end else if (m_cnt == m_div) begin
                m_cnt = 0; m_div = int'(div_val); m_cclk = ~m_cclk;
                if (m_cclk) begin
                    m_phase = (m_phase + 1) % 4;
                    m_div2  = ~m_div2;
                    m_lo    = (Q_PHASE != 0) ? 1'((m_phase >> 1) ^ (m_phase & 1)) : 1'(m_phase >> 1);
                end
            end else begin
                m_cnt++;
            end
            if (en) m_ts = m_ts + 16'd1;
            h_hb[2] = h_hb[1]; h_hb[1] = h_hb[0]; h_hb[0] = high_buf;
            h_phi[2] = h_phi[1]; h_phi[1] = h_phi[0]; h_phi[0] = phi1b_dig;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cclk", 32'(cclk), 32'({8{m_cclk}}));
            check("div2", 32'(div2), 32'({8{m_div2}}));
            check("lo", 32'(lo), 32'({8{m_lo}}));
            check("fb1", 32'(fb1), 32'(m_fb1));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("ev_valid", 32'(ev_if.ev_valid), 32'(m_q.size() != 0));
            check("ev_data", 32'(ev_if.ev_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] mask);
        @(negedge clk) phi1b_dig = mask;
        @(negedge clk) phi1b_dig = 8'd0;
    endtask

    function automatic logic sel_sig(input int which);
        case (which)
            0:       return cclk[0];
            1:       return div2[0];
            default: return lo[0];
        endcase
    endfunction

    task automatic rise_period(input int which, output int per);
        int   first;
        logic prev, cur;
        first = -1; per = -1;
        prev = sel_sig(which);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            cur = sel_sig(which);
            if (cur && !prev) begin
                if (first < 0) first = n;
                else begin per = n - first; break; end
            end
            prev = cur;
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int          per, last_d2, lag;
        logic        pd2, plo;
        logic [15:0] a_ts;
        ev_if.ev_ready = 1'b0;
        div_val = 8'd2;
        #3;
        check("reset_cclk", 32'(cclk), 32'd0);
        check("reset_div2", 32'(div2), 32'd0);
        check("reset_lo", 32'(lo), 32'd0);
        check("reset_fb1", 32'(fb1), 32'd0);
        check("reset_ev_valid", 32'(ev_if.ev_valid), 32'd0);
        check("reset_ev_data", 32'(ev_if.ev_data), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);

        @(negedge clk) begin rst_n = 1'b1; en = 1'b1; end
        wait_n(5);
        check("model_ts_after_5", 32'(m_ts), 32'd5);

        // Clock generation with div_val = 2.
        rise_period(0, per); check("cclk_period", 32'(per), 32'd6);
        rise_period(1, per); check("div2_period", 32'(per), 32'd12);
        rise_period(2, per); check("lo_period", 32'(per), 32'd24);
        last_d2 = -1000; lag = -1;
        pd2 = div2[0]; plo = lo[0];
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (div2[0] && !pd2) last_d2 = n;
            if (lo[0] && !plo && last_d2 >= 0) begin lag = n - last_d2; break; end
            pd2 = div2[0]; plo = lo[0];
        end
        check("lo_lag_div2", 32'(lag), 32'd6);

        // Channel 3 event latency.
        @(negedge clk) high_buf = 8'h08;
        wait_n(3);
        @(negedge clk) begin phi1b_dig = 8'h08; a_ts = m_ts; end
        @(negedge clk) check("ch3_fb1_k", 32'(fb1[3]), 32'd0);
        @(negedge clk) check("ch3_fb1_k1", 32'(fb1[3]), 32'd0);
        @(negedge clk) begin
            check("ch3_fb1_k2", 32'(fb1[3]), 32'd1);
            check("ch3_valid_k2", 32'(ev_if.ev_valid), 32'd0);
        end
        @(negedge clk) begin
            check("ch3_valid_k3", 32'(ev_if.ev_valid), 32'd1);
            check("ch3_data", 32'(ev_if.ev_data), 32'({3'd3, 1'b1, a_ts + 16'd2}));
            ev_if.ev_ready = 1'b1;
        end
        @(negedge clk) begin ev_if.ev_ready = 1'b0; phi1b_dig = 8'h00; end
        wait_n(3);
        @(negedge clk) phi1b_dig = 8'h08;
        wait_n(6);
        check("ch3_repeat_no_event", 32'(ev_if.ev_valid), 32'd0);

        // Channels 1 and 5 detected in the same cycle.
        @(negedge clk) begin phi1b_dig = 8'h00; high_buf = 8'h2A; end
        wait_n(3);
        @(negedge clk) begin phi1b_dig = 8'h22; a_ts = m_ts; end
        wait_n(4);
        check("pair_first", 32'(ev_if.ev_data), 32'({3'd1, 1'b1, a_ts + 16'd2}));
        ev_if.ev_ready = 1'b1;
        @(negedge clk) begin
            ev_if.ev_ready = 1'b0;
            check("pair_second", 32'(ev_if.ev_data), 32'({3'd5, 1'b1, a_ts + 16'd2}));
            ev_if.ev_ready = 1'b1;
        end
        @(negedge clk) begin
            ev_if.ev_ready = 1'b0;
            check("pair_empty", 32'(ev_if.ev_valid), 32'd0);
            check("pair_ovf", 32'(ovf), 32'd0);
            phi1b_dig = 8'h00;
        end
        wait_n(3);

        // Ten events with the consumer stalled.
        @(negedge clk) high_buf = 8'hD5;
        pulse(8'hFF);
        wait_n(12);
        check("full_valid", 32'(ev_if.ev_valid), 32'd1);
        check("full_no_ovf", 32'(ovf), 32'd0);
        @(negedge clk) high_buf = 8'hD0;
        pulse(8'h05);
        wait_n(5);
        check("ten_events_no_ovf", 32'(ovf), 32'd0);
        @(negedge clk) high_buf = 8'hD1;
        pulse(8'h01);
        wait_n(5);
        check("pending_overwrite_ovf", 32'(ovf), 32'd1);
        @(negedge clk) ovf_clr = 1'b1;
        @(negedge clk) begin ovf_clr = 1'b0; check("ovf_cleared", 32'(ovf), 32'd0); end
        @(negedge clk) begin high_buf = 8'hD5; phi1b_dig = 8'h04; end
        @(negedge clk) phi1b_dig = 8'h00;
        @(negedge clk) ovf_clr = 1'b1;
        @(negedge clk) begin ovf_clr = 1'b0; check("ovf_set_beats_clr", 32'(ovf), 32'd1); end
        @(negedge clk) check("ovf_sticky", 32'(ovf), 32'd1);
        ev_if.ev_ready = 1'b1;
        for (int n = 0; n < 40 && ev_if.ev_valid; n++) @(negedge clk);
        check("drain_empty", 32'(ev_if.ev_valid), 32'd0);
        ev_if.ev_ready = 1'b0;

        // Enable dropped with events queued.
        @(negedge clk) high_buf = high_buf ^ 8'hC0;
        pulse(8'hC0);
        wait_n(6);
        @(negedge clk) en = 1'b0;
        @(negedge clk) begin
            check("en_off_cclk", 32'(cclk), 32'd0);
            check("en_off_div2", 32'(div2), 32'd0);
            check("en_off_lo", 32'(lo), 32'd0);
            a_ts = m_ts;
            ev_if.ev_ready = 1'b1;
        end
        wait_n(4);
        check("en_off_drained", 32'(ev_if.ev_valid), 32'd0);
        check("model_ts_frozen", 32'(m_ts), 32'(a_ts));
        @(negedge clk) begin ev_if.ev_ready = 1'b0; en = 1'b1; end

        // Asynchronous reset with events queued.
        @(negedge clk) high_buf = high_buf ^ 8'h0F;
        pulse(8'h0F);
        wait_n(8);
        check("pre_reset_valid", 32'(ev_if.ev_valid), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(ev_if.ev_valid), 32'd0);
        check("async_rst_fb1", 32'(fb1), 32'd0);
        check("async_rst_ovf", 32'(ovf), 32'd0);
        check("async_rst_cclk", 32'(cclk), 32'd0);
        @(negedge clk) begin high_buf = 8'd0; phi1b_dig = 8'd0; end
        #2 rst_n = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            phi1b_dig = phi1b_dig ^ (8'($urandom) & 8'($urandom));
            high_buf  = 8'($urandom);
            ev_if.ev_ready = ((c % 400) < 100) ? 1'b0 : ($urandom_range(0, 2) != 0);
            ovf_clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) en = ~en;
            if (!en && $urandom_range(0, 15) == 0) en = 1'b1;
            if (c % 250 == 0) div_val = 8'($urandom_range(0, 3));
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cochlea_chan_ctrl.md
Name: cochlea_chan_ctrl

Overview:
- Digital-side counterpart of the 8-channel analog cochlea core.
- Drives the channel clocks (cclk, div2), the local-oscillator select (lo) and the filter feedback (fb1).
- Receives the comparator outputs (high_buf) and the per-channel event clocks (phi1b_dig), then converts comparator polarity changes into timestamped events in an output FIFO.

Parameters:
- N_CH, 8, number of analog channels (channel index is 3 bits).
- DIV_W, 8, width of the cclk prescaler value.
- TS_W, 16, timestamp width.
- FIFO_DEPTH, 8, event FIFO entries (power of 2).
- Q_PHASE, 0, 0 = I-path lo phasing, 1 = Q-path (lo shifted 90 degrees).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable.
- div_val  in  DIV_W  cclk half-period minus 1, in clk cycles.
- high_buf  in  N_CH  comparator outputs from the analog core; asynchronous.
- phi1b_dig  in  N_CH  event clocks from the analog core; asynchronous.
- cclk  out  N_CH  channel clock (all bits identical).
- div2  out  N_CH  cclk/2 (all bits identical).
- lo  out  N_CH  LO mux select (all bits identical).
- fb1  out  N_CH  per-channel feedback = last sampled comparator decision.
- ev_valid  out  1  FIFO not empty.
- ev_ready  in  1  consumer pop.
- ev_data  out  3+1+TS_W  {chan[2:0], pol, ts}, FIFO head.
- ovf  out  1  sticky event-loss flag.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset: all outputs 0. Prescaler, phase counter, timestamp, sync flops, pending bits and FIFO pointers are all 0.
- Clock generation:
  - Prescaler counts 0..div_val. At terminal count it wraps to 0 and toggles cclk_int.
  - div_val is sampled only at the wrap; div_val = 0 gives cclk = clk/2.
  - On each cclk_int rising toggle, a 2-bit phase counter increments and div2 toggles.
  - lo = phase[1] when Q_PHASE = 0; lo = phase[1]^phase[0] when Q_PHASE = 1.
  - All outputs are registered and fanned out to N_CH identical bits.
- en = 0:
  - Prescaler, phase, cclk, div2 and lo are forced to 0; the timestamp is frozen.
  - fb1 holds; edge detection is suppressed.
  - The FIFO still drains.
- Timestamp: free-running TS_W counter incrementing every clk while en = 1; wraps silently.
- Sampling path:
  - high_buf and phi1b_dig each pass through a 2-flop synchronizer.
  - A phi1b rising edge is detected from the synced value versus its delayed copy.
  - On that edge, d = synced high_buf[i] and fb1[i] <= d.
  - Latency: inputs stable before clk edge k -> fb1 changes at edge k+2.
- Event detection:
  - On the phi1b edge, if d != current fb1[i], set pend[i], pend_pol[i] = d and pend_ts[i] = timestamp.
  - If pend[i] is already set, set ovf and overwrite with the newer pol/ts. One event is lost.
- Arbiter:
  - Each cycle, the lowest-index pend bit is pushed to the FIFO if the FIFO is not full. Its pend bit clears in the same cycle.
  - FIFO full -> no push; pend bits hold.
  - A same-cycle new detection on the channel being pushed: the pushed entry is the old one, and pend stays set with the new data (not an overflow).
- FIFO:
  - Push and pop in the same cycle leave the count unchanged.
  - Pop when empty is ignored.
  - Push only when count < FIFO_DEPTH; no bypass of the full condition.
  - ev_data is valid whenever ev_valid = 1; there is no ready-to-valid combinational path.
- ovf:
  - Cleared by ovf_clr.
  - A simultaneous set and clear leaves ovf = 1.
- Reset mid-operation: everything returns to reset values immediately; FIFO contents are discarded.

Test Plan:
- div_val = 2, en = 1 after reset:
  - cclk period = 6 clk, div2 period = 12 clk.
  - lo (Q_PHASE = 0) period = 24 clk and lags div2 by one cclk period; with Q_PHASE = 1, lo leads by 90 degrees.
- Channel 3: high_buf = 1, then phi1b_dig rises at edge k:
  - fb1[3] = 1 at edge k+2.
  - ev_valid rises at edge k+3 with ev_data = {3, 1, ts_at_k+2}.
  - Repeating with high_buf still 1 -> no new event.
- phi1b_dig rises on channels 5 and 1 in the same cycle, both with polarity changes -> the chan 1 entry is popped first, then chan 5, with equal ts. ovf stays 0.
- ev_ready = 0 with 10 distinct events:
  - 8 entries are stored; 2 remain pending with no loss, and ovf = 0.
  - A further change on a pending channel -> ovf = 1.
  - ovf_clr asserted in the same cycle as a new overflow -> ovf stays 1.
- Drop en mid-run -> cclk/div2/lo = 0 next edge; the timestamp freezes and queued events still pop.
- Assert rst_n = 0 with 4 events queued -> ev_valid = 0, fb1 = 0 and ovf = 0 asynchronously.
